// File: rtl/chngy_pkg.sv
// Shared types and constants for the change-in-Y update controller.
// Holds the FSM encoding, datapath mode codes, complex word layout and Y address packing.
package chngy_pkg;

    localparam int unsigned N_BUS      = 14;
    localparam int unsigned BUS_W      = 4;
    localparam int unsigned ADDR_W     = 2 * BUS_W;
    localparam int unsigned DP_TIMEOUT = 64;
    localparam int unsigned CPLX_W     = 48;
    localparam int unsigned PART_W     = CPLX_W / 2;
    localparam int unsigned REC_CNT_W  = 16;
    localparam int unsigned WAIT_W     = $clog2(DP_TIMEOUT + 1);

    localparam logic DP_ADD = 1'b1;
    localparam logic DP_SUB = 1'b0;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD      = 3'd1,
        ISSUE   = 3'd2,
        WAIT_DP = 3'd3,
        WR      = 3'd4,
        ABORT   = 3'd5
    } ctrlState_e;

    // Complex admittance word: real part in the upper half.
    typedef struct packed {
        logic [PART_W-1:0] re;
        logic [PART_W-1:0] im;
    } cplx_t;

    function automatic logic [ADDR_W-1:0] packAddr(input logic [BUS_W-1:0] row,
                                                   input logic [BUS_W-1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/chngy_entry_seq.sv
// Entry sequencer: tracks the bus pair and entry index of the current record and
// produces the Y address and add/sub mode of the entry that will be current next cycle.
module chngy_entry_seq
    import chngy_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              advance,
    input  logic [BUS_W-1:0]  loadBusI,
    input  logic [BUS_W-1:0]  loadBusJ,
    output logic [ADDR_W-1:0] nextAddr_c,
    output logic              nextMode_c,
    output logic              lastEntry_c
);

    localparam int unsigned IDX_W = 2;
    localparam int unsigned CNT_W = 3;

    logic [BUS_W-1:0] busI;
    logic [BUS_W-1:0] busJ;
    logic [BUS_W-1:0] busINext;
    logic [BUS_W-1:0] busJNext;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idxNext;
    logic [CNT_W-1:0] entryCount;

    always_comb begin
        busINext = busI;
        busJNext = busJ;
        idxNext  = idx;
        if (load) begin
            busINext = loadBusI;
            busJNext = loadBusJ;
            idxNext  = '0;
        end else if (advance) begin
            idxNext = idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busI <= '0;
            busJ <= '0;
            idx  <= '0;
        end else begin
            busI <= busINext;
            busJ <= busJNext;
            idx  <= idxNext;
        end
    end

    // A shunt change touches only the diagonal entry.
    assign entryCount  = (busI == busJ) ? CNT_W'(1) : CNT_W'(4);
    assign lastEntry_c = ((CNT_W'(idx) + CNT_W'(1)) == entryCount);

    // Order: (i,i) add, (j,j) add, (i,j) sub, (j,i) sub.
    always_comb begin
        nextAddr_c = packAddr(busINext, busINext);
        nextMode_c = DP_ADD;
        case (idxNext)
            2'd0: begin
                nextAddr_c = packAddr(busINext, busINext);
                nextMode_c = DP_ADD;
            end
            2'd1: begin
                nextAddr_c = packAddr(busJNext, busJNext);
                nextMode_c = DP_ADD;
            end
            2'd2: begin
                nextAddr_c = packAddr(busINext, busJNext);
                nextMode_c = DP_SUB;
            end
            default: begin
                nextAddr_c = packAddr(busJNext, busINext);
                nextMode_c = DP_SUB;
            end
        endcase
    end

endmodule

// File: rtl/chngy_update_ctrl.sv
// Change-in-Y update controller: read-modify-write of each Y entry touched by a
// line-change record through the external complex add/sub datapath.
module chngy_update_ctrl
    import chngy_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BUS_W-1:0]     in_bus_i,
    input  logic [BUS_W-1:0]     in_bus_j,
    input  logic [CPLX_W-1:0]    in_dy,
    output logic                 mem_rd_en,
    output logic                 mem_wr_en,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [CPLX_W-1:0]    mem_wdata,
    input  logic [CPLX_W-1:0]    mem_rdata,
    output logic                 dp_enable,
    output logic                 dp_mode,
    output logic [CPLX_W-1:0]    dp_in1,
    output logic [CPLX_W-1:0]    dp_in2,
    input  logic                 dp_done,
    input  logic [CPLX_W-1:0]    dp_result,
    output logic                 rec_done,
    output logic                 err_range,
    output logic                 err_timeout,
    output logic [REC_CNT_W-1:0] rec_count
);

    ctrlState_e state;
    ctrlState_e nextState;

    logic              accept;
    logic              badIndex;
    logic              seqLoad;
    logic              seqAdvance;
    logic              rangeFault;
    logic              recFinish;
    logic [ADDR_W-1:0] nextAddr;
    logic              nextMode;
    logic              lastEntry;
    logic [CPLX_W-1:0] dyReg;
    logic [WAIT_W-1:0] waitCnt;

    chngy_entry_seq u_entrySeq (
        .clock       (clock),
        .reset       (reset),
        .load        (seqLoad),
        .advance     (seqAdvance),
        .loadBusI    (in_bus_i),
        .loadBusJ    (in_bus_j),
        .nextAddr_c  (nextAddr),
        .nextMode_c  (nextMode),
        .lastEntry_c (lastEntry)
    );

    assign badIndex = (in_bus_i >= BUS_W'(N_BUS)) || (in_bus_j >= BUS_W'(N_BUS));

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState  = state;
        seqLoad    = 1'b0;
        seqAdvance = 1'b0;
        rangeFault = 1'b0;
        recFinish  = 1'b0;
        accept     = (state == IDLE) && in_ready && in_valid;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (badIndex) begin
                        rangeFault = 1'b1;
                    end else begin
                        seqLoad   = 1'b1;
                        nextState = RD;
                    end
                end
            end
            RD:      nextState = ISSUE;
            ISSUE:   nextState = WAIT_DP;
            WAIT_DP: begin
                // A result arriving on the last allowed cycle still wins over the timeout.
                if (dp_done) begin
                    nextState = WR;
                    recFinish = lastEntry;
                end else if (waitCnt == WAIT_W'(DP_TIMEOUT - 1)) begin
                    nextState = ABORT;
                end
            end
            WR: begin
                if (lastEntry) begin
                    nextState = IDLE;
                end else begin
                    seqAdvance = 1'b1;
                    nextState  = RD;
                end
            end
            ABORT:   nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state they belong to.
    always_ff @(posedge clock) begin
        if (reset) begin
            in_ready    <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            dp_enable   <= 1'b0;
            dp_mode     <= DP_SUB;
            dp_in1      <= '0;
            dp_in2      <= '0;
            rec_done    <= 1'b0;
            err_range   <= 1'b0;
            err_timeout <= 1'b0;
            rec_count   <= '0;
            dyReg       <= '0;
            waitCnt     <= '0;
        end else begin
            in_ready  <= (nextState == IDLE);
            mem_rd_en <= (nextState == RD);
            mem_wr_en <= (nextState == WR);
            dp_enable <= (nextState == ISSUE) || (nextState == WAIT_DP);
            rec_done  <= recFinish;
            err_range <= rangeFault;

            if (nextState == ABORT) begin
                err_timeout <= 1'b1;
            end
            if (recFinish) begin
                rec_count <= rec_count + REC_CNT_W'(1);
            end
            if (seqLoad) begin
                dyReg <= in_dy;
            end
            if (nextState == RD) begin
                mem_addr <= nextAddr;
            end
            if (nextState == ISSUE) begin
                dp_mode <= nextMode;
                dp_in2  <= dyReg;
            end
            // Read data lands during ISSUE; hold it as the first operand until the next entry.
            if (state == ISSUE) begin
                dp_in1 <= mem_rdata;
            end
            if ((state == WAIT_DP) && dp_done) begin
                mem_wdata <= dp_result;
            end

            if ((state == ISSUE) || (state == WAIT_DP)) begin
                waitCnt <= waitCnt + WAIT_W'(1);
            end else begin
                waitCnt <= '0;
            end
        end
    end

endmodule
